mine_placer: RTL and testbench
==============================

// Module: mine_placer
// PURPOSE
//  Responder to the game FSM's mine_start/mine_done handshake. On request, clears the
//  16x16 board's mine bits, then places NUM_MINES mines at pseudo-random distinct cells.
//  Mines are never placed on the player's chosen start cell, or on its 8 neighbours when
//  EXCLUDE_NEIGHBORS=1. Writes go to the board mine memory through a simple write port.
// PARAMETERS
//  NUM_MINES          40        mines to place; legal range 1..247 (1..255 if EXCLUDE_NEIGHBORS=0)
//  LFSR_SEED          16'hACE1  LFSR reset value; must be nonzero
//  EXCLUDE_NEIGHBORS  1         1 = exclude the start cell plus its 3x3 neighbourhood; 0 = start cell only
// PORTS
//  clk              in   1  system clock
//  rst              in   1  asynchronous reset, active-low
//  mine_start       in   1  level request from game FSM; held high for the whole placement
//  start_cell_addr  in   8  chosen start cell, {row[3:0],col[3:0]}
//  mine_done        out  1  placement complete; held high until mine_start drops
//  busy             out  1  high in CLEAR and PLACE
//  board_we         out  1  board memory write strobe, one write per cycle
//  board_addr       out  8  board memory write address
//  board_mine       out  1  write data: 0 = clear, 1 = mine
//  mines_placed     out  8  mines written so far in the current run
// BEHAVIOUR
//  Reset (rst=0): state=IDLE. All outputs 0, occupancy vector 0, lfsr=LFSR_SEED. Takes effect immediately.
//  LFSR: 16-bit Galois, mask 16'hB400, free-running every cycle in every state. Candidate = lfsr[7:0].
//  States:
//   IDLE:  if mine_start=1: latch start_cell_addr, clear occ[255:0], mines_placed<=0, clear counter<=0, ->CLEAR.
//   CLEAR: board_we=1, board_mine=0, board_addr=counter. Counter runs 0..255, one address per cycle.
//          After the write to address 255, ->PLACE. Takes exactly 256 cycles.
//   PLACE: each cycle, test the candidate. It is rejected if occ[cand]=1 or cand is excluded.
//          Excluded = the latched start cell, or (EXCLUDE_NEIGHBORS and |drow|<=1 and |dcol|<=1).
//          Row and column differences are computed as 4-bit unsigned fields, with no wrap across edges.
//          Rejected: board_we=0, no state change.
//          Accepted: board_we=1, board_addr=cand, board_mine=1, occ[cand]<=1, mines_placed++.
//          If the accepted write makes mines_placed==NUM_MINES, ->DONE on the same edge.
//   DONE:  mine_done=1, busy=0, board_we=0. Hold until mine_start=0, then ->IDLE. mines_placed is retained.
//  Abort: mine_start=0 in CLEAR or PLACE -> IDLE next edge. mine_done is never asserted for that run;
//   writes already made are left in memory.
//  board_addr/board_mine are don't-care when board_we=0. All outputs are registered (Moore).
//  Latency: mine_done rises at least 256+NUM_MINES+1 cycles after mine_start rises.
//   Exact count is deterministic for a given seed and number of cycles since reset.
//  No duplicate addresses are written with board_mine=1 within one run.
//  mine_start rising again after DONE->IDLE starts a full new run (clear + place).
// TESTING
//  1 reset, start=8'h00, NUM_MINES=40 -> 256 writes (addr 0..255, data 0); then 40 distinct data=1 writes,
//    none at 00/01/10/11; mine_done=1 held until mine_start=0; mines_placed=40.
//  2 start=8'h77 -> no mine at any of 66..68, 76..78, 86..88; exactly NUM_MINES mine writes.
//  3 NUM_MINES=247, start=8'h88 -> every non-excluded cell written exactly once; run terminates;
//    mines_placed=247.
//  4 drop mine_start at CLEAR cycle 100 -> IDLE next edge, mine_done stays 0;
//    reassert -> clear restarts at addr 0, mines_placed=0.
//  5 rst low mid-PLACE -> all outputs 0 asynchronously; after release, identical stimulus
//    reproduces an identical write sequence.
//  6 EXCLUDE_NEIGHBORS=0, start=8'hFF, NUM_MINES=255 -> all cells except FF mined; corner start has no wrap.

Source files
------------

// File: rtl/mine_placer_if.sv
// Handshake and board write port between the game FSM (master) and the mine placer (slave).
interface mine_placer_if;
  logic       mine_start;
  logic [7:0] start_cell_addr;
  logic       mine_done;
  logic       busy;
  logic       board_we;
  logic [7:0] board_addr;
  logic       board_mine;
  logic [7:0] mines_placed;

  modport master (
    output mine_start, start_cell_addr,
    input  mine_done, busy, board_we, board_addr, board_mine, mines_placed
  );

  modport slave (
    input  mine_start, start_cell_addr,
    output mine_done, busy, board_we, board_addr, board_mine, mines_placed
  );
endinterface

// File: rtl/mine_placer.sv
// Clears the 16x16 mine board, then scatters NUM_MINES distinct mines from a free-running
// LFSR, keeping the player's start cell (and optionally its neighbourhood) mine-free.
module mine_placer #(
  parameter int          NUM_MINES         = 40,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1,
  parameter bit          EXCLUDE_NEIGHBORS = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  mine_placer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, PLACE, DONE} state_t;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic       mine;
  } wr_t;

  localparam logic [7:0] LAST_MINE = 8'(NUM_MINES - 1);

  state_t       state;
  wr_t          wr;
  logic [15:0]  lfsr, lfsr_nxt;
  logic [255:0] occ;
  logic [7:0]   start_q, cand, placed;
  logic         done_q, busy_q;
  logic [3:0]   drow, dcol;
  logic         excluded, accept;

  function automatic logic [3:0] absdiff(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Row/column distances are plain 4-bit magnitudes, so the neighbourhood never wraps at edges.
  always_comb begin
    lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    cand     = lfsr[7:0];
    drow     = absdiff(cand[7:4], start_q[7:4]);
    dcol     = absdiff(cand[3:0], start_q[3:0]);
    excluded = (cand == start_q) ||
               (EXCLUDE_NEIGHBORS && (drow <= 4'd1) && (dcol <= 4'd1));
    accept   = !occ[cand] && !excluded;
  end

  // Outputs are registered: a PLACE decision on one edge shows up as the write of the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      wr      <= '0;
      lfsr    <= LFSR_SEED;
      occ     <= '0;
      start_q <= '0;
      placed  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      lfsr <= lfsr_nxt;
      case (state)
        IDLE: begin
          wr.we  <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.mine_start) begin
            start_q <= bus.start_cell_addr;
            occ     <= '0;
            placed  <= '0;
            wr      <= '{we: 1'b1, addr: 8'h00, mine: 1'b0};
            busy_q  <= 1'b1;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          if (!bus.mine_start) begin
            wr.we  <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (wr.addr == 8'hFF) begin
            wr.we <= 1'b0;
            state <= PLACE;
          end else begin
            wr.addr <= wr.addr + 8'd1;
          end
        end
        PLACE: begin
          if (!bus.mine_start) begin
            wr.we  <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (accept) begin
            wr        <= '{we: 1'b1, addr: cand, mine: 1'b1};
            occ[cand] <= 1'b1;
            placed    <= placed + 8'd1;
            if (placed == LAST_MINE) state <= DONE;
          end else begin
            wr.we <= 1'b0;
          end
        end
        DONE: begin
          wr.we  <= 1'b0;
          busy_q <= 1'b0;
          if (!bus.mine_start) begin
            done_q <= 1'b0;
            state  <= IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mine_done    = done_q;
  assign bus.busy         = busy_q;
  assign bus.board_we     = wr.we;
  assign bus.board_addr   = wr.addr;
  assign bus.board_mine   = wr.mine;
  assign bus.mines_placed = placed;

endmodule

// File: tb/tb_mine_placer.sv
// Directed bench for mine_placer: three instances cover the default, full-board and no-neighbour cases.
module tb_mine_placer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mine_placer_if if0 ();
  mine_placer_if if1 ();
  mine_placer_if if2 ();

  mine_placer #(.NUM_MINES(40))                         u_a (.clk(clk), .rst(rst), .bus(if0));
  mine_placer #(.NUM_MINES(247))                        u_b (.clk(clk), .rst(rst), .bus(if1));
  mine_placer #(.NUM_MINES(255), .EXCLUDE_NEIGHBORS(1'b0)) u_c (.clk(clk), .rst(rst), .bus(if2));

  logic [2:0] st;
  logic [7:0] sc [3];
  logic       we [3], bm [3], dn [3], bz [3];
  logic [7:0] ad [3], mp [3];

  assign if0.mine_start = st[0];  assign if0.start_cell_addr = sc[0];
  assign if1.mine_start = st[1];  assign if1.start_cell_addr = sc[1];
  assign if2.mine_start = st[2];  assign if2.start_cell_addr = sc[2];

  assign we[0] = if0.board_we;  assign bm[0] = if0.board_mine;  assign ad[0] = if0.board_addr;
  assign dn[0] = if0.mine_done; assign bz[0] = if0.busy;        assign mp[0] = if0.mines_placed;
  assign we[1] = if1.board_we;  assign bm[1] = if1.board_mine;  assign ad[1] = if1.board_addr;
  assign dn[1] = if1.mine_done; assign bz[1] = if1.busy;        assign mp[1] = if1.mines_placed;
  assign we[2] = if2.board_we;  assign bm[2] = if2.board_mine;  assign ad[2] = if2.board_addr;
  assign dn[2] = if2.mine_done; assign bz[2] = if2.busy;        assign mp[2] = if2.mines_placed;

  // Reference LFSR: m_prev is the value every DUT used as its candidate on the latest edge.
  logic [15:0] m_lfsr, m_prev;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Write monitor per instance.
  logic [2:0] mon_clr;
  int         clr_next [3], clr_err [3], mlen [3], lfsr_err [3];
  int         mcnt [3][256];
  logic [7:0] mlog [3][256];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (mon_clr[i]) begin
        clr_next[i] <= 0;
        clr_err[i]  <= 0;
        mlen[i]     <= 0;
        lfsr_err[i] <= 0;
        for (int a = 0; a < 256; a++) mcnt[i][a] <= 0;
      end else if (we[i]) begin
        if (!bm[i]) begin
          if (ad[i] != 8'(clr_next[i])) clr_err[i] <= clr_err[i] + 1;
          clr_next[i] <= clr_next[i] + 1;
        end else begin
          mcnt[i][ad[i]] <= mcnt[i][ad[i]] + 1;
          if (mlen[i] < 256) mlog[i][mlen[i]] <= ad[i];
          mlen[i] <= mlen[i] + 1;
          if (ad[i] != m_prev[7:0]) lfsr_err[i] <= lfsr_err[i] + 1;
        end
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon(input logic [2:0] m);
    mon_clr = m;
    tick(1);
    mon_clr = 3'b000;
  endtask

  task automatic wait_done(input int i, input int budget, input string tag, output int cyc);
    cyc = 0;
    while (!dn[i] && cyc < budget) begin
      tick(1);
      cyc++;
    end
    chk(tag, int'(dn[i]), 1);
  endtask

  function automatic int dups(input int i);
    int d = 0;
    for (int a = 0; a < 256; a++) if (mcnt[i][a] > 1) d++;
    return d;
  endfunction

  function automatic int excl_hits(input int i, input logic [7:0] s);
    int h = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int r, c;
        r = int'(s[7:4]) + dr;
        c = int'(s[3:0]) + dc;
        if (r >= 0 && r < 16 && c >= 0 && c < 16) h += mcnt[i][r*16 + c];
      end
    end
    return h;
  endfunction

  // Cells whose mine count differs from "1 unless excluded, else 0".
  function automatic int place_mism(input int i, input logic [7:0] s, input bit nb);
    int m = 0;
    for (int a = 0; a < 256; a++) begin
      int r, c, dr, dc;
      bit ex;
      r  = a / 16;
      c  = a % 16;
      dr = (r > int'(s[7:4])) ? r - int'(s[7:4]) : int'(s[7:4]) - r;
      dc = (c > int'(s[3:0])) ? c - int'(s[3:0]) : int'(s[3:0]) - c;
      ex = (a == int'(s)) || (nb && dr <= 1 && dc <= 1);
      if (mcnt[i][a] != (ex ? 0 : 1)) m++;
    end
    return m;
  endfunction

  int         cyc, diffs;
  logic [7:0] ref_log [40];

  initial begin
    st      = 3'b000;
    sc      = '{default: 8'h00};
    mon_clr = 3'b000;
    rst     = 1'b1;
    #2 rst  = 1'b0;
    tick(3);
    chk("rst_we",    int'(we[0]), 0);
    chk("rst_busy",  int'(bz[0]), 0);
    chk("rst_done",  int'(dn[0]), 0);
    chk("rst_mp",    int'(mp[0]), 0);
    chk("rst_addr",  int'(ad[0]), 0);
    rst = 1'b1;
    tick(2);

    // Corner start: clear sweep, then 40 distinct mines away from 00/01/10/11.
    clear_mon(3'b001);
    sc[0] = 8'h00; st[0] = 1'b1;
    wait_done(0, 3000, "t1_done", cyc);
    chk("t1_latency_min",  int'(cyc >= 297), 1);
    chk("t1_mines_placed", int'(mp[0]), 40);
    chk("t1_clear_count",  clr_next[0], 256);
    chk("t1_clear_order",  clr_err[0], 0);
    chk("t1_mine_writes",  mlen[0], 40);
    chk("t1_dups",         dups(0), 0);
    chk("t1_excl_hits",    excl_hits(0, 8'h00), 0);
    chk("t1_lfsr_cand",    lfsr_err[0], 0);
    tick(5);
    chk("t1_done_held",    int'(dn[0]), 1);
    chk("t1_busy_in_done", int'(bz[0]), 0);
    chk("t1_we_in_done",   int'(we[0]), 0);
    chk("t1_no_extra",     mlen[0], 40);
    st[0] = 1'b0;
    tick(1);
    chk("t1_done_drop",    int'(dn[0]), 0);
    chk("t1_mp_retained",  int'(mp[0]), 40);

    // Centre start: 3x3 block around 77 stays clear.
    clear_mon(3'b001);
    sc[0] = 8'h77; st[0] = 1'b1;
    wait_done(0, 3000, "t2_done", cyc);
    chk("t2_mine_writes",  mlen[0], 40);
    chk("t2_dups",         dups(0), 0);
    chk("t2_excl_hits",    excl_hits(0, 8'h77), 0);
    chk("t2_mines_placed", int'(mp[0]), 40);
    chk("t2_lfsr_cand",    lfsr_err[0], 0);
    st[0] = 1'b0;
    tick(2);

    // Abort in CLEAR while address 100 is on the bus, then restart from scratch.
    clear_mon(3'b001);
    sc[0] = 8'h00; st[0] = 1'b1;
    tick(101);
    chk("t4_addr_at_100",  int'(ad[0]), 100);
    chk("t4_busy_clear",   int'(bz[0]), 1);
    chk("t4_mp_reset",     int'(mp[0]), 0);
    st[0] = 1'b0;
    tick(1);
    chk("t4_abort_we",     int'(we[0]), 0);
    chk("t4_abort_busy",   int'(bz[0]), 0);
    tick(3);
    chk("t4_abort_done",   int'(dn[0]), 0);
    chk("t4_clears_made",  clr_next[0], 101);
    clear_mon(3'b001);
    st[0] = 1'b1;
    tick(1);
    chk("t4_restart_we",   int'(we[0]), 1);
    chk("t4_restart_addr", int'(ad[0]), 0);
    chk("t4_restart_mp",   int'(mp[0]), 0);
    wait_done(0, 3000, "t4_done", cyc);
    chk("t4_clear_count",  clr_next[0], 256);
    chk("t4_clear_order",  clr_err[0], 0);
    chk("t4_mine_writes",  mlen[0], 40);
    st[0] = 1'b0;
    tick(2);

    // Reset mid-PLACE; identical stimulus after reset must repeat the write sequence.
    rst = 1'b0; tick(2); rst = 1'b1; tick(3);
    clear_mon(3'b001);
    sc[0] = 8'h35; st[0] = 1'b1;
    wait_done(0, 3000, "t5_ref_done", cyc);
    for (int k = 0; k < 40; k++) ref_log[k] = mlog[0][k];
    st[0] = 1'b0;
    tick(2);
    rst = 1'b0; tick(2); rst = 1'b1; tick(3);
    clear_mon(3'b001);
    st[0] = 1'b1;
    cyc = 0;
    while (mlen[0] < 10 && cyc < 3000) begin
      tick(1);
      cyc++;
    end
    chk("t5_reached_place", int'(mlen[0] >= 10), 1);
    rst = 1'b0;
    #1;
    chk("t5_async_we",   int'(we[0]), 0);
    chk("t5_async_busy", int'(bz[0]), 0);
    chk("t5_async_done", int'(dn[0]), 0);
    chk("t5_async_mp",   int'(mp[0]), 0);
    chk("t5_async_addr", int'(ad[0]), 0);
    chk("t5_async_mine", int'(bm[0]), 0);
    st[0] = 1'b0;
    tick(2); rst = 1'b1; tick(3);
    clear_mon(3'b001);
    st[0] = 1'b1;
    wait_done(0, 3000, "t5_rerun_done", cyc);
    diffs = 0;
    for (int k = 0; k < 40; k++) if (mlog[0][k] != ref_log[k]) diffs++;
    chk("t5_same_sequence", diffs, 0);
    chk("t5_mine_writes",   mlen[0], 40);
    st[0] = 1'b0;
    tick(2);

    // Full-board runs in parallel: 247 around 88 with neighbours, 255 around FF without.
    clear_mon(3'b110);
    sc[1] = 8'h88; sc[2] = 8'hFF;
    st[1] = 1'b1;  st[2] = 1'b1;
    cyc = 0;
    while (!(dn[1] && dn[2]) && cyc < 20000) begin
      tick(1);
      cyc++;
    end
    chk("t3_done",          int'(dn[1]), 1);
    chk("t3_mines_placed",  int'(mp[1]), 247);
    chk("t3_cell_mism",     place_mism(1, 8'h88, 1'b1), 0);
    chk("t3_clear_count",   clr_next[1], 256);
    chk("t3_lfsr_cand",     lfsr_err[1], 0);
    chk("t6_done",          int'(dn[2]), 1);
    chk("t6_mines_placed",  int'(mp[2]), 255);
    chk("t6_cell_mism",     place_mism(2, 8'hFF, 1'b0), 0);
    chk("t6_start_clear",   mcnt[2][8'hFF], 0);
    chk("t6_neigh_fe",      mcnt[2][8'hFE], 1);
    chk("t6_neigh_ee",      mcnt[2][8'hEE], 1);
    chk("t6_lfsr_cand",     lfsr_err[2], 0);
    st[1] = 1'b0; st[2] = 1'b0;
    tick(1);
    chk("t6_done_drop",     int'(dn[2]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
